// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the four-digit multiplexed display scanner.
// Holds the scan phase enum and the digit count.
package digit_scan_pkg;
  localparam int NDIG = 4;

  typedef enum logic {
    S_GUARD,
    S_ON
  } state_t;
endpackage

// File: rtl/digit_scan.sv
// Multiplexed 4-digit hex display scanner with frame-synchronous value update.
// Ports: clk, reset (sync, active high), value/load in, ack/num/dig_n out.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int DIV      = 50000,
  parameter int GUARD    = 16,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic        ack,
  output logic [3:0]  num,
  output logic [3:0]  dig_n
);

  localparam int CW = 20;
  localparam logic [CW-1:0] G_END = CW'(GUARD - 1);
  localparam logic [CW-1:0] D_END = CW'(DIV - 1);

  state_t          st, st_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [15:0]     shadow;
  logic [15:0]     pending;
  logic            pend_vld;
  logic            boundary;
  logic            blank;
  logic [3:0]      nib;
  logic [15:0]     upper;
  logic [3:0]      dig_nxt;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    unique case (st)
      S_GUARD: begin
        if (cnt == G_END) begin
          st_nxt  = S_ON;
          cnt_nxt = '0;
        end
      end
      S_ON: begin
        if (cnt == D_END) begin
          st_nxt  = S_GUARD;
          cnt_nxt = '0;
          idx_nxt = idx + 2'd1;
        end
      end
      default: begin
        st_nxt  = S_GUARD;
        cnt_nxt = '0;
      end
    endcase
  end

  // Last ON cycle of digit 3 closes the frame.
  assign boundary = (st == S_ON) && (cnt == D_END) && (idx == 2'd3);

  assign nib   = shadow[{idx, 2'b00} +: 4];
  // Digit idx is a leading zero when it and everything above it is zero.
  assign upper = shadow >> {idx, 2'b00};
  assign blank = (BLANK_LZ != 0) && (idx != 2'd0) && (upper == 16'h0);

  assign dig_nxt = (st == S_ON && !blank) ? ~(4'b0001 << idx) : 4'hF;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_GUARD;
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
      pending  <= '0;
      pend_vld <= 1'b0;
      ack      <= 1'b0;
      num      <= 4'h0;
      dig_n    <= 4'hF;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      dig_n <= dig_nxt;
      ack   <= boundary && pend_vld;
      if (st == S_ON) num <= nib;
      if (boundary && pend_vld) shadow <= pending;
      // A load in the boundary cycle survives into the next frame.
      if (load) begin
        pending  <= value;
        pend_vld <= 1'b1;
      end else if (boundary) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan with DIV=4, GUARD=2, one instance per blanking mode.
// Scoreboard queue holds values expected to be committed at frame boundaries.
module tb_digit_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        ack_b, ack_n;
  logic [3:0]  num_b, num_n;
  logic [3:0]  dig_b, dig_n;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sbq[$];
  bit          pend = 1'b0;
  bit          live = 1'b0;
  logic        ack_b_q = 1'b0;
  logic        ack_n_q = 1'b0;
  logic [15:0] cur;

  always #5 clk = ~clk;

  digit_scan #(.DIV(4), .GUARD(2), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .ack(ack_b), .num(num_b), .dig_n(dig_b)
  );

  digit_scan #(.DIV(4), .GUARD(2), .BLANK_LZ(0)) dut_n (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .ack(ack_n), .num(num_n), .dig_n(dig_n)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("onehot_b", 16'($countones(~dig_b) <= 1), 16'd1);
      chk("onehot_n", 16'($countones(~dig_n) <= 1), 16'd1);
      chk("ack2_b", 16'(ack_b && ack_b_q), 16'd0);
      chk("ack2_n", 16'(ack_n && ack_n_q), 16'd0);
      ack_b_q = ack_b;
      ack_n_q = ack_n;
    end
  end

  function automatic logic [3:0] exp_dig(input logic [15:0] v, input int j,
                                         input bit bl);
    int slot;
    logic [15:0] up;
    slot = j / 6;
    up   = v >> (4 * slot);
    if ((j % 6) < 2) return 4'hF;
    if (bl && slot > 0 && up == 16'h0) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  task automatic run_frame(input logic [15:0] v, input int la,
                           input logic [15:0] va, input int lb,
                           input logic [15:0] vb, output logic [15:0] nxt);
    bit commit;
    logic [3:0] en;
    commit = 1'b0;
    nxt    = v;
    for (int j = 0; j < 24; j++) begin
      if (j == 23) begin
        commit = pend;
        pend   = 1'b0;
      end
      if (j == la || j == lb) begin
        value = (j == la) ? va : vb;
        load  = 1'b1;
        if (pend) sbq[sbq.size()-1] = value;
        else sbq.push_back(value);
        pend = 1'b1;
      end
      tick();
      load = 1'b0;
      chk($sformatf("dig_b[%0d]", j), 16'(dig_b), 16'(exp_dig(v, j, 1'b1)));
      chk($sformatf("dig_n[%0d]", j), 16'(dig_n), 16'(exp_dig(v, j, 1'b0)));
      if ((j % 6) >= 2) begin
        en = v[4*(j/6) +: 4];
        chk($sformatf("num_b[%0d]", j), 16'(num_b), 16'(en));
        chk($sformatf("num_n[%0d]", j), 16'(num_n), 16'(en));
      end
      chk($sformatf("ack_b[%0d]", j), 16'(ack_b), 16'(j == 23 && commit));
      chk($sformatf("ack_n[%0d]", j), 16'(ack_n), 16'(j == 23 && commit));
    end
    if (commit) begin
      chk("sb_nonempty", 16'(sbq.size() > 0), 16'd1);
      if (sbq.size() > 0) nxt = sbq.pop_front();
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b1;
    value = 16'h9999;
    tick();
    chk("rst_dig_b", 16'(dig_b), 16'hF);
    chk("rst_num_b", 16'(num_b), 16'h0);
    chk("rst_ack_b", 16'(ack_b), 16'h0);
    chk("rst_dig_n", 16'(dig_n), 16'hF);
    reset = 1'b0;
    load  = 1'b0;
    live  = 1'b1;

    cur = 16'h0;
    run_frame(cur, -1, 16'h0, -1, 16'h0, cur);
    run_frame(cur, 3, 16'h1234, -1, 16'h0, cur);
    chk("disp_1234", cur, 16'h1234);
    run_frame(cur, 5, 16'h0050, -1, 16'h0, cur);
    run_frame(cur, 4, 16'h0000, -1, 16'h0, cur);
    run_frame(cur, 1, 16'hAAAA, 10, 16'hBEEF, cur);
    chk("disp_beef", cur, 16'hBEEF);
    run_frame(cur, 5, 16'h2222, 23, 16'h1111, cur);
    chk("disp_2222", cur, 16'h2222);
    run_frame(cur, -1, 16'h0, -1, 16'h0, cur);
    chk("disp_1111", cur, 16'h1111);
    run_frame(cur, -1, 16'h0, -1, 16'h0, cur);

    value = 16'h5555;
    load  = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    chk("pre_rst_dig", 16'(dig_b), 16'b1011);
    chk("pre_rst_num", 16'(num_b), 16'h1);
    reset = 1'b1;
    tick();
    chk("mid_rst_dig_b", 16'(dig_b), 16'hF);
    chk("mid_rst_num_b", 16'(num_b), 16'h0);
    chk("mid_rst_ack_b", 16'(ack_b), 16'h0);
    chk("mid_rst_dig_n", 16'(dig_n), 16'hF);
    chk("mid_rst_num_n", 16'(num_n), 16'h0);
    reset = 1'b0;
    sbq.delete();
    pend = 1'b0;
    cur  = 16'h0;
    run_frame(cur, -1, 16'h0, -1, 16'h0, cur);
    run_frame(cur, -1, 16'h0, -1, 16'h0, cur);

    live = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 Parameter DIV, default 50000: number of clk cycles each digit is lit (ON phase), legal range 2..2^20.
REQ-002 Parameter GUARD, default 16: number of all-digits-off clk cycles before each ON phase (anti-ghosting), legal range 1..255.
REQ-003 Parameter BLANK_LZ, default 1: 1 enables leading-zero suppression, 0 disables it.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 value  input  16  four hex nibbles to display; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 load  input  1  one-cycle request to display value; value sampled in the same cycle.
REQ-008 ack  output  1  one-cycle pulse when a requested value becomes the displayed value.
REQ-009 num  output  4  nibble for the downstream hex-to-segment decoder.
REQ-010 dig_n  output  4  active-low digit enables; bit i drives digit i; at most one bit low.

Function
REQ-011 Internal registers: shadow (16-bit, displayed), pending (16-bit), pend_vld, digit index idx (2-bit), phase state, prescale counter.
REQ-012 States: GUARD (all digits off, GUARD cycles) and ON (digit idx lit, DIV cycles); GUARD->ON when the counter reaches GUARD-1; ON->GUARD when it reaches DIV-1; the counter clears on every transition.
REQ-013 On ON->GUARD, idx increments modulo 4 (0,1,2,3,0...).
REQ-014 Frame boundary = the ON->GUARD transition with idx==3; frame length = 4*(DIV+GUARD) cycles.
REQ-015 load: pending<=value, pend_vld<=1; repeated loads in a frame overwrite pending (latest wins), producing one ack only.
REQ-016 At a frame boundary with pend_vld==1: shadow<=pending, pend_vld<=0, ack=1 for exactly that cycle's next cycle (registered, one-cycle pulse).
REQ-017 load in the frame-boundary cycle: captured into pending and committed at the next boundary; the commit in that cycle uses the previous pending content.
REQ-018 Outputs registered: dig_n and num reflect state/idx with 1-cycle latency.
REQ-019 In GUARD: dig_n=4'b1111, num holds its previous value.
REQ-020 In ON: num=shadow nibble idx; dig_n has bit idx low unless that digit is blanked.
REQ-021 Blanking (BLANK_LZ=1): digit i in 1..3 is blanked when shadow nibbles i..3 are all zero; digit 0 is never blanked; blanked digit gives dig_n=4'b1111 for its ON slot, timing unchanged.
REQ-022 Shadow changes only at frame boundaries; no frame ever mixes two values.

Reset
REQ-023 reset (any cycle, including mid-ON or commit cycle) sets: shadow=0, pending=0, pend_vld=0, idx=0, state GUARD, counter 0.
REQ-024 Outputs in the cycle after reset asserted: dig_n=4'b1111, num=4'h0, ack=0; a load coincident with reset is discarded.

Structure
REQ-025 Package digit_scan_pkg holds the state enum (GUARD, ON) and NDIG=4 constant.
REQ-026 No sub-module; the prescaler is inline; the hex-to-segment decoder is instantiated beside this block by the parent, not inside it.

Verification (DIV=4, GUARD=2, BLANK_LZ=1 unless stated)
REQ-027 Reset, load 16'h1234 -> one ack at first frame boundary; then repeating: 2 cycles 1111, 4 cycles dig_n=1110 num=4, 2 off, 1101/3, 2 off, 1011/2, 2 off, 0111/1; frame = 24 cycles.
REQ-028 Load 16'h0050 -> digits 3,2 dark in their slots, digit 1 shows 5, digit 0 shows 0; load 16'h0000 -> only digit 0 lit with 0; with BLANK_LZ=0, 16'h0050 lights all four (0,0,5,0).
REQ-029 Load 16'hAAAA then 16'hBEEF in the same frame -> single ack; next frame shows F,E,E,B; AAAA never displayed.
REQ-030 Load 16'h1111 in the boundary cycle while pending=16'h2222 -> 2222 committed with ack now; 1111 committed with second ack 24 cycles later.
REQ-031 Assert reset during digit 2 ON slot -> next cycle dig_n=1111, num=0, ack=0, pending lost; after 2 GUARD cycles digit 0 lit showing 0, digits 1-3 blanked.
REQ-032 Throughout all scenarios, assertion: dig_n never has more than one bit low, and ack is never high two consecutive cycles.
